// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage. Completes loads by waiting for the data
// SRAM response, buffers that response while write-back stalls, and passes
// non-load results straight through. Also drives the stall and forward
// buses back to decode.
module mem_stage #(
   parameter int unsigned ES_TO_MS_WD = 72,
   parameter int unsigned MS_TO_WS_WD = 71
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ws_allowin,
   output logic                   ms_allowin,
   input  logic                   es_to_ms_valid,
   input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
   output logic                   ms_to_ws_valid,
   output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
   output logic [5:0]             stall_ms_bus,
   output logic [32:0]            forward_ms_bus,
   input  logic [31:0]            data_sram_rdata,
   input  logic                   data_sram_data_ok
);

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned DEST_W    = 5;
   localparam int unsigned RES_BIT   = 71;
   localparam int unsigned GR_WE_BIT = 70;
   localparam int unsigned HL_WE_BIT = 69;
   localparam int unsigned DEST_LSB  = 64;
   localparam int unsigned ALU_LSB   = 32;
   localparam int unsigned PC_LSB    = 0;

   logic                   ms_valid;
   logic [ES_TO_MS_WD-1:0] es_to_ms_bus_r;
   logic                   buf_valid;
   logic [DATA_W-1:0]      buf_data;

   logic                   ms_ready_go;
   logic                   res_from_mem;
   logic                   gr_we;
   logic                   hl_we;
   logic [DEST_W-1:0]      dest;
   logic [DATA_W-1:0]      alu_result;
   logic [DATA_W-1:0]      pc;
   logic [DATA_W-1:0]      load_data;
   logic [DATA_W-1:0]      final_result;
   logic                   ms_leave;
   logic                   buf_capture;

   // Unpack the held execute payload
   always_comb begin
      res_from_mem = es_to_ms_bus_r[RES_BIT];
      gr_we        = es_to_ms_bus_r[GR_WE_BIT];
      hl_we        = es_to_ms_bus_r[HL_WE_BIT];
      dest         = es_to_ms_bus_r[DEST_LSB +: DEST_W];
      alu_result   = es_to_ms_bus_r[ALU_LSB +: DATA_W];
      pc           = es_to_ms_bus_r[PC_LSB +: DATA_W];
   end

   // Handshake, result selection and outgoing buses
   always_comb begin
      ms_ready_go    = res_from_mem ? (buf_valid || data_sram_data_ok) : 1'b1;
      ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
      ms_to_ws_valid = ms_valid && ms_ready_go;
      ms_leave       = ms_valid && ms_ready_go && ws_allowin;
      // Only the first response of a load is kept; later pulses are dropped
      buf_capture    = ms_valid && res_from_mem && data_sram_data_ok
                       && !buf_valid && !ws_allowin;
      load_data      = buf_valid ? buf_data : data_sram_rdata;
      final_result   = res_from_mem ? load_data : alu_result;
      ms_to_ws_bus   = {gr_we, hl_we, dest, final_result, pc};
      // A waiting load does not forward; decode stalls on stall_ms_bus instead
      forward_ms_bus = {ms_valid && ms_ready_go, final_result};
      stall_ms_bus   = {ms_valid && gr_we, dest};
   end

   // Stage valid and payload register
   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid       <= 1'b0;
         es_to_ms_bus_r <= '0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
         if (es_to_ms_valid) begin
            es_to_ms_bus_r <= es_to_ms_bus;
         end
      end
   end

   // Load response buffer; leaving the stage takes priority over capture
   always_ff @(posedge clk) begin
      if (reset) begin
         buf_valid <= 1'b0;
         buf_data  <= '0;
      end else if (ms_leave) begin
         buf_valid <= 1'b0;
      end else if (buf_capture) begin
         buf_valid <= 1'b1;
         buf_data  <= data_sram_rdata;
      end
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Fourth pipeline stage, directly downstream of the execute stage and upstream of write-back.
- Accepts the execute-to-memory bus and completes loads by waiting for the data SRAM read response.
- Response data is buffered while write-back stalls. Non-load results pass through unchanged.
- Drives stall and forward buses back to decode, and the memory-to-write-back bus.

Parameters:
- ES_TO_MS_WD, 72, width of incoming bus: {res_from_mem[71], gr_we[70], hl_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- MS_TO_WS_WD, 71, width of outgoing bus: {gr_we[70], hl_we[69], dest[68:64], final_result[63:32], pc[31:0]}

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ws_allowin  in  1  write-back can accept
- ms_allowin  out  1  this stage can accept
- es_to_ms_valid  in  1  execute bus valid
- es_to_ms_bus  in  ES_TO_MS_WD  execute payload
- ms_to_ws_valid  out  1  outgoing bus valid
- ms_to_ws_bus  out  MS_TO_WS_WD  outgoing payload
- stall_ms_bus  out  6  {ms_valid && gr_we, dest}
- forward_ms_bus  out  33  {forward_valid, final_result}
- data_sram_rdata  in  32  load data
- data_sram_data_ok  in  1  single-cycle pulse; rdata valid this cycle

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high.
  - Reset clears ms_valid, buf_valid, buf_data and the payload register to 0.
  - After reset, ms_to_ws_valid=0, ms_allowin=1, stall_ms_bus=0, forward_ms_bus=0.
- Registers: ms_valid, payload register es_to_ms_bus_r, buf_valid, buf_data[31:0].
- Handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - When ms_allowin: ms_valid <= es_to_ms_valid.
  - When es_to_ms_valid && ms_allowin: es_to_ms_bus_r <= es_to_ms_bus.
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - Payload is held stable while ms_valid && !ms_allowin.
- Ready condition:
  - Non-load (res_from_mem=0): ms_ready_go = 1. Latency 1 cycle; no bubble inserted.
  - Load (res_from_mem=1): ms_ready_go = buf_valid || data_sram_data_ok.
- Load data selection:
  - load_data = buf_valid ? buf_data : data_sram_rdata.
  - final_result = res_from_mem ? load_data : alu_result.
- Response buffer:
  - Capture when ms_valid && res_from_mem && data_sram_data_ok && !buf_valid && !ws_allowin: buf_valid<=1, buf_data<=rdata.
  - Clear buf_valid when ms_valid && ms_ready_go && ws_allowin (instruction leaves).
  - If capture and leave occur in the same cycle, leave wins (buf_valid<=0).
- data_ok pulses are ignored when:
  - ms_valid=0,
  - the current instruction is a non-load, or
  - buf_valid=1 (at most one response per load).
- Multi-cycle load stall: while waiting, ms_allowin=0 and the upstream stage holds its bus.
- Forwarding:
  - forward_valid = ms_valid && ms_ready_go.
  - A waiting load does not forward; decode must use stall_ms_bus.
- stall_ms_bus dest field = dest from the payload register, independent of ms_valid. Valid bit = ms_valid && gr_we.
- ms_to_ws_bus = {gr_we, hl_we, dest, final_result, pc}. hl_we passes through unchanged.
- Reset mid-load:
  - Outstanding load is dropped; buf_valid=0.
  - A data_ok arriving the cycle after reset is ignored, since ms_valid=0.
- Back-to-back loads: the second load enters only in the cycle the first leaves. Its data_ok is honoured from its first valid cycle onward.

Test Plan:
- Non-load pass-through: es bus {res_from_mem=0, gr_we=1, dest=5, alu=0x1234, pc=0xBFC00000}, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x1234, forward_ms_bus={1,0x1234}, stall_ms_bus={1,5}.
- Load, data_ok 3 cycles after entry, ws_allowin=1:
  - ms_allowin=0 and forward_valid=0 for 2 cycles.
  - In the data_ok cycle, rdata=0xDEADBEEF gives ms_to_ws_valid=1 and final_result=0xDEADBEEF.
  - ms_allowin=1 in that same cycle.
- Load with data_ok while ws_allowin=0 (rdata=0xCAFEF00D), ws_allowin raised 2 cycles later:
  - buf_valid=1 with result held.
  - A second data_ok (rdata=0x0) is ignored.
  - Output 0xCAFEF00D on release; buf_valid=0 afterwards.
- Write-back backpressure on non-load: ws_allowin=0 for 4 cycles -> ms_allowin=0, payload stable, no new es bus accepted; release -> one transfer.
- Reset during a waiting load: assert reset 1 cycle; data_ok pulse next cycle -> ms_valid=0, buf_valid=0, no ms_to_ws_valid.
- Back-to-back loads A, B with data_ok in consecutive cycles (ws_allowin=1) -> A leaves with rdata1 in cycle n, B enters n+1 and leaves with rdata2; no data loss or duplication.
